// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- UART transmitter fed from a FIFO. The frame format is fixed
// at elaboration time by the parameters.
//
// Frame on tx: start bit (0), DATA_BITS data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits (1). Every bit is held for
// DIV = round(CLK_HZ / BAUD) sclk cycles. tx is driven from a flop.
//
// Ports
//   sclk          clock
//   reset         asynchronous reset, active low
//   enable        allows a new frame to start; the frame in flight always finishes
//   fifo_empty    source FIFO empty flag
//   fifo_rd_data  source FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    single-cycle pop strobe, at most one per frame
//   tx            serial line, idles high
//   busy          high from FETCH through the last stop bit
//   tx_done       one-cycle pulse on the final cycle of the last stop bit
module uart_tx_cfg #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  // Refuse to build an unusable configuration
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_HZ/BAUD gives a divider below 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baudCnt_q, baudCnt_d;
  logic [3:0]           bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shiftReg_q, shiftReg_d;
  logic                 parBit_q, parBit_d;
  logic                 tx_q, tx_d;
  logic                 started_q;
  logic                 baudEnd;
  logic                 popOk;

  assign tx = tx_q;

  // State register. started_q keeps the first pop from being requested
  // before the first clock edge after reset has been released.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      parBit_q   <= 1'b0;
      tx_q       <= 1'b1;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
      parBit_q   <= parBit_d;
      tx_q       <= tx_d;
      started_q  <= 1'b1;
    end
  end

  // Next state and outputs. tx_d always carries the level of the bit that
  // starts on the next edge, so tx changes exactly on bit boundaries.
  always_comb begin
    state_d    = state_q;
    baudCnt_d  = baudCnt_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    parBit_d   = parBit_q;
    tx_d       = tx_q;
    fifo_rd_en = 1'b0;
    tx_done    = 1'b0;
    busy       = (state_q != IDLE);
    baudEnd    = (baudCnt_q == BAUD_LAST);
    popOk      = started_q & enable & ~fifo_empty;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (popOk) begin
          fifo_rd_en = 1'b1;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        shiftReg_d = fifo_rd_data;
        parBit_d   = (^fifo_rd_data) ^ PAR_ODD;
        baudCnt_d  = '0;
        bitCnt_d   = '0;
        tx_d       = 1'b0;
        state_d    = START;
      end

      START: begin
        if (baudEnd) begin
          baudCnt_d = '0;
          tx_d      = shiftReg_q[0];
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + CNT_ONE;
        end
      end

      // bit 0 of the shift register is always the bit currently on the line
      DATA: begin
        if (baudEnd) begin
          baudCnt_d  = '0;
          shiftReg_d = {1'b0, shiftReg_q[DATA_BITS-1:1]};
          if (bitCnt_q == DATA_LAST) begin
            bitCnt_d = '0;
            if (PARITY != 0) begin
              tx_d    = parBit_q;
              state_d = PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
            tx_d     = shiftReg_q[1];
          end
        end else begin
          baudCnt_d = baudCnt_q + CNT_ONE;
        end
      end

      PAR: begin
        if (baudEnd) begin
          baudCnt_d = '0;
          bitCnt_d  = '0;
          tx_d      = 1'b1;
          state_d   = STOP;
        end else begin
          baudCnt_d = baudCnt_q + CNT_ONE;
        end
      end

      // The last cycle of the last stop bit is also the decision point for
      // an immediate follow-on frame.
      STOP: begin
        if (baudEnd) begin
          baudCnt_d = '0;
          if (bitCnt_q == STOP_LAST) begin
            bitCnt_d = '0;
            tx_done  = 1'b1;
            tx_d     = 1'b1;
            if (popOk) begin
              fifo_rd_en = 1'b1;
              state_d    = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q + CNT_ONE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg -- directed bench for uart_tx_cfg at DIV = 10.
// Three instances share clock and reset:
//   [0] 8N1, [1] 7E2, [2] 7O1 (7-bit odd parity).
// Each instance has a small FIFO model whose read data is valid the
// cycle after the pop strobe. Frames are sampled every cycle at the falling
// edge and compared against hand-computed bit vectors. In these vectors bit 0
// is the start bit, followed by the data (LSB first), the parity bit and the
// stop bits.
module tb_uart_tx_cfg;

  localparam int DIV = 10;

  logic       sclk = 1'b0;
  logic       reset;
  logic [2:0] enableV;
  logic [2:0] emptyV;
  logic [2:0] rdEnV;
  logic [2:0] txV;
  logic [2:0] busyV;
  logic [2:0] doneV;
  logic [7:0] rdDataV [3] = '{default: 8'h00};
  logic [7:0] fifoMem [3][16];
  int         wrPtr [3] = '{0, 0, 0};
  int         rdPtr [3] = '{0, 0, 0};
  int         popCnt [3] = '{0, 0, 0};
  int         lastPopCyc [3] = '{0, 0, 0};
  int         badPops = 0;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 sclk = ~sclk;

  uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u8n1 (
    .sclk(sclk), .reset(reset), .enable(enableV[0]), .fifo_empty(emptyV[0]),
    .fifo_rd_data(rdDataV[0]), .fifo_rd_en(rdEnV[0]), .tx(txV[0]),
    .busy(busyV[0]), .tx_done(doneV[0]));

  uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u7e2 (
    .sclk(sclk), .reset(reset), .enable(enableV[1]), .fifo_empty(emptyV[1]),
    .fifo_rd_data(rdDataV[1][6:0]), .fifo_rd_en(rdEnV[1]), .tx(txV[1]),
    .busy(busyV[1]), .tx_done(doneV[1]));

  uart_tx_cfg #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u7o1 (
    .sclk(sclk), .reset(reset), .enable(enableV[2]), .fifo_empty(emptyV[2]),
    .fifo_rd_data(rdDataV[2][6:0]), .fifo_rd_en(rdEnV[2]), .tx(txV[2]),
    .busy(busyV[2]), .tx_done(doneV[2]));

  assign emptyV[0] = (wrPtr[0] == rdPtr[0]);
  assign emptyV[1] = (wrPtr[1] == rdPtr[1]);
  assign emptyV[2] = (wrPtr[2] == rdPtr[2]);

  // FIFO models and pop bookkeeping. A pop takes effect on the edge that
  // ends the strobe cycle. lastPopCyc records the number of that cycle.
  always @(posedge sclk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rdEnV[i]) begin
        popCnt[i]     <= popCnt[i] + 1;
        lastPopCyc[i] <= cyc;
        if (emptyV[i]) begin
          badPops <= badPops + 1;
        end else begin
          rdDataV[i] <= fifoMem[i][rdPtr[i] % 16];
          rdPtr[i]   <= rdPtr[i] + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] data);
    fifoMem[idx][wrPtr[idx] % 16] = data;
    wrPtr[idx] = wrPtr[idx] + 1;
  endtask

  // Returns at the falling edge of the first start-bit cycle.
  task automatic waitStart(input string tag, input int idx, output int startCyc);
    logic found;
    found    = 1'b0;
    startCyc = -1;
    for (int n = 0; n < 500; n++) begin
      @(negedge sclk);
      if (txV[idx] == 1'b0) begin
        found    = 1'b1;
        startCyc = cyc;
        break;
      end
    end
    checkOutput({tag, "_startSeen"}, 32'(found), 32'd1);
  endtask

  // Must be called on the first start-bit cycle. Returns on the tx_done cycle.
  task automatic checkFrame(input string tag, input int idx, input int nBits,
                            input logic [15:0] expBits, input logic expPop);
    logic [15:0] bits;
    int          unstable;
    int          doneAt;
    int          doneCnt;
    int          idleCnt;
    logic        popAtEnd;
    bits     = '0;
    unstable = 0;
    doneAt   = -1;
    doneCnt  = 0;
    idleCnt  = 0;
    popAtEnd = 1'b0;
    for (int k = 0; k < nBits * DIV; k++) begin
      if (k > 0) @(negedge sclk);
      if (k % DIV == 0) bits[k / DIV] = txV[idx];
      else if (txV[idx] !== bits[k / DIV]) unstable++;
      if (doneV[idx]) begin
        doneAt = k;
        doneCnt++;
      end
      if (!busyV[idx]) idleCnt++;
      popAtEnd = rdEnV[idx];
    end
    checkOutput({tag, "_bits"}, 32'(bits), 32'(expBits));
    checkOutput({tag, "_bitHold"}, 32'(unstable), 32'd0);
    checkOutput({tag, "_doneCycle"}, 32'(doneAt), 32'(nBits * DIV - 1));
    checkOutput({tag, "_donePulses"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, "_busy"}, 32'(idleCnt), 32'd0);
    checkOutput({tag, "_popAtDone"}, 32'(popAtEnd), 32'(expPop));
  endtask

  // Watches one instance for a quiet window: tx high, not busy.
  task automatic checkQuiet(input string tag, input int idx, input int cycles);
    int txLow;
    int busyHigh;
    txLow    = 0;
    busyHigh = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge sclk);
      if (txV[idx] !== 1'b1) txLow++;
      if (busyV[idx] !== 1'b0) busyHigh++;
    end
    checkOutput({tag, "_txLow"}, 32'(txLow), 32'd0);
    checkOutput({tag, "_busyHigh"}, 32'(busyHigh), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int popBase;

    reset   = 1'b1;
    enableV = 3'b111;
    #2 reset = 1'b0;

    // a word waits in the 7E2 FIFO while reset is held
    applyStimulus(1, 8'h41);
    repeat (3) @(negedge sclk);
    #1;
    checkOutput("rstTx", 32'(txV), 32'h7);
    checkOutput("rstBusy", 32'(busyV), 32'h0);
    checkOutput("rstDone", 32'(doneV), 32'h0);
    checkOutput("rstPop", 32'(rdEnV), 32'h0);
    @(negedge sclk);
    reset = 1'b1;
    #1;
    checkOutput("popBeforeEdge", 32'(rdEnV[1]), 32'd0);

    // 7E2, 0x41: 0, 1000001, parity 0, 1, 1  (110 cycles)
    waitStart("e2", 1, s);
    checkOutput("e2_latency", 32'(s - lastPopCyc[1]), 32'd2);
    checkFrame("e2_41", 1, 11, 16'h0682, 1'b0);
    checkQuiet("e2_after", 1, 5);
    checkOutput("e2_pops", 32'(popCnt[1]), 32'd1);

    // 8N1, 0x55: 0,1,0,1,0,1,0,1,0,1
    applyStimulus(0, 8'h55);
    waitStart("n1", 0, s);
    checkOutput("n1_latency", 32'(s - lastPopCyc[0]), 32'd2);
    checkFrame("n1_55", 0, 10, 16'h02AA, 1'b0);
    checkQuiet("n1_after", 0, 5);
    checkOutput("n1_pops", 32'(popCnt[0]), 32'd1);

    // 7O1: payload 0x00 needs parity 1; the 7-bit payload of 0xFF has seven ones, so parity 0
    applyStimulus(2, 8'h00);
    waitStart("o1a", 2, s);
    checkFrame("o1_00", 2, 10, 16'h0300, 1'b0);
    applyStimulus(2, 8'hFF);
    waitStart("o1b", 2, s);
    checkFrame("o1_FF", 2, 10, 16'h02FE, 1'b0);

    // back-to-back: the pop on the tx_done cycle, then one FETCH cycle, then START
    popBase = popCnt[0];
    applyStimulus(0, 8'hA5);
    applyStimulus(0, 8'h3C);
    waitStart("b2b", 0, s);
    checkFrame("b2b_A5", 0, 10, 16'h034A, 1'b1);
    @(negedge sclk);
    checkOutput("b2b_fetchTx", 32'(txV[0]), 32'd1);
    checkOutput("b2b_fetchBusy", 32'(busyV[0]), 32'd1);
    @(negedge sclk);
    checkOutput("b2b_secondStart", 32'(txV[0]), 32'd0);
    checkFrame("b2b_3C", 0, 10, 16'h0278, 1'b0);
    checkQuiet("b2b_after", 0, 5);
    checkOutput("b2b_pops", 32'(popCnt[0] - popBase), 32'd2);

    // enable drops while a frame is on the line, with a second word queued
    popBase = popCnt[0];
    applyStimulus(0, 8'h55);
    applyStimulus(0, 8'hA5);
    waitStart("en", 0, s);
    enableV[0] = 1'b0;
    checkFrame("en_55", 0, 10, 16'h02AA, 1'b0);
    checkQuiet("en_off", 0, 50);
    checkOutput("en_offPops", 32'(popCnt[0] - popBase), 32'd1);
    enableV[0] = 1'b1;
    waitStart("en_on", 0, s);
    checkFrame("en_A5", 0, 10, 16'h034A, 1'b0);
    checkOutput("en_onPops", 32'(popCnt[0] - popBase), 32'd2);

    // reset in cycle 45 of a frame, and nothing is queued behind that frame
    popBase = popCnt[0];
    applyStimulus(0, 8'h3C);
    waitStart("ab", 0, s);
    repeat (45) @(negedge sclk);
    reset = 1'b0;
    #1;
    checkOutput("ab_tx", 32'(txV[0]), 32'd1);
    checkOutput("ab_busy", 32'(busyV[0]), 32'd0);
    checkOutput("ab_done", 32'(doneV[0]), 32'd0);
    checkOutput("ab_pop", 32'(rdEnV[0]), 32'd0);
    repeat (3) @(negedge sclk);
    reset = 1'b1;
    checkQuiet("ab_after", 0, 50);
    checkOutput("ab_pops", 32'(popCnt[0] - popBase), 32'd1);

    checkOutput("popWhileEmpty", 32'(badPops), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
